ibex_multdiv_ctrl: RTL

Two-port controller that shares one `ibex_multdiv_fast` instance between the core EX stage (port 0) and a coprocessor/accelerator port (port 1). It arbitrates requests and latches operands. It drives the unit's enables and operands stable for the whole operation, captures the result on the unit's valid, and returns it with a requester ID under valid/ready backpressure. An optional last-result cache returns repeated operations without engaging the unit.

---
 rtl/ibex_pkg.sv | 30 +++
 rtl/ibex_multdiv_arb.sv | 35 +++
 rtl/ibex_multdiv_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide controller: unit operator encoding,
// controller FSM states and the request record used by ports, latch and cache.
package ibex_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'b00,
      MD_OP_MULH = 2'b01,
      MD_OP_DIV  = 2'b10,
      MD_OP_REM  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } md_ctrl_fsm_e;

   // signed_mode: bit0 = operand A signed, bit1 = operand B signed
   typedef struct packed {
      md_op_e      op;
      logic [1:0]  signed_mode;
      logic [31:0] op_a;
      logic [31:0] op_b;
   } md_req_t;

   function automatic logic md_is_mult(input md_op_e op);
      return (op == MD_OP_MULL) || (op == MD_OP_MULH);
   endfunction

endpackage

// File: rtl/ibex_multdiv_arb.sv
// Two-way request arbiter: round-robin on the last accepted grant (ARB_RR=1)
// or fixed priority with port 0 winning (ARB_RR=0).
module ibex_multdiv_arb #(
   parameter bit ARB_RR = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   logic r_last;
   logic w_pick1;

   // Resetting last-grant to port 1 lets port 0 win the first contention.
   always_comb begin
      if (ARB_RR) begin
         w_pick1 = req_i[1] & (~req_i[0] | ~r_last);
      end else begin
         w_pick1 = req_i[1] & ~req_i[0];
      end
   end

   assign gnt_o = {w_pick1, req_i[0] & ~w_pick1};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= 1'b1;
      end else if (accept_i) begin
         r_last <= w_pick1;
      end
   end

endmodule

// File: rtl/ibex_multdiv_ctrl.sv
// Shares one ibex_multdiv_fast between the EX stage (port 0) and a coprocessor
// port (port 1). Define IBEX_MULTDIV_CACHE_EN for a one-entry last-result cache.
module ibex_multdiv_ctrl
   import ibex_pkg::*;
#(
   parameter bit ARB_RR = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  md_op_e      req0_operator_i,
   input  logic [1:0]  req0_signed_mode_i,
   input  logic [31:0] req0_op_a_i,
   input  logic [31:0] req0_op_b_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  md_op_e      req1_operator_i,
   input  logic [1:0]  req1_signed_mode_i,
   input  logic [31:0] req1_op_a_i,
   input  logic [31:0] req1_op_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [31:0] rsp_result_o,
   output logic        md_mult_en_o,
   output logic        md_div_en_o,
   output md_op_e      md_operator_o,
   output logic [1:0]  md_signed_mode_o,
   output logic [31:0] md_op_a_o,
   output logic [31:0] md_op_b_o,
   output logic        md_equal_to_zero_o,
   input  logic [31:0] md_result_i,
   input  logic        md_valid_i
);

   md_ctrl_fsm_e r_state, w_state_nxt;
   md_req_t      r_req, w_req0, w_req1, w_sel;
   logic         r_id;
   logic [31:0]  r_result, w_hit_data;
   logic [1:0]   w_gnt;
   logic         w_accept, w_done, w_hit;

   assign w_req0 = '{op: req0_operator_i, signed_mode: req0_signed_mode_i,
                     op_a: req0_op_a_i, op_b: req0_op_b_i};
   assign w_req1 = '{op: req1_operator_i, signed_mode: req1_signed_mode_i,
                     op_a: req1_op_a_i, op_b: req1_op_b_i};
   assign w_sel    = w_gnt[1] ? w_req1 : w_req0;
   assign w_accept = (r_state == IDLE) && (w_gnt != 2'b00);
   assign w_done   = (r_state == BUSY) && md_valid_i;

   ibex_multdiv_arb #(
      .ARB_RR (ARB_RR)
   ) u_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    ({req1_valid_i, req0_valid_i}),
      .accept_i (w_accept),
      .gnt_o    (w_gnt)
   );

`ifdef IBEX_MULTDIV_CACHE_EN
   logic        r_cache_vld;
   md_req_t     r_cache_key;
   logic [31:0] r_cache_data;

   // Refilled on every unit completion; only reset clears the valid bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cache_vld  <= 1'b0;
         r_cache_key  <= '0;
         r_cache_data <= '0;
      end else if (w_done) begin
         r_cache_vld  <= 1'b1;
         r_cache_key  <= r_req;
         r_cache_data <= md_result_i;
      end
   end

   assign w_hit      = r_cache_vld && (r_cache_key == w_sel);
   assign w_hit_data = r_cache_data;
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = '0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_state_nxt = w_hit ? RESP : BUSY;
         BUSY:    if (md_valid_i) w_state_nxt = RESP;
         RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Leaving BUSY on md_valid_i drops the enables next cycle, so the unit never restarts.
   always_comb begin
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      rsp_valid_o  = 1'b0;
      md_mult_en_o = 1'b0;
      md_div_en_o  = 1'b0;
      unique case (r_state)
         IDLE: begin
            req0_ready_o = w_gnt[0];
            req1_ready_o = w_gnt[1];
         end
         BUSY: begin
            md_mult_en_o = md_is_mult(r_req.op);
            md_div_en_o  = ~md_is_mult(r_req.op);
         end
         RESP:    rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req    <= '0;
         r_id     <= 1'b0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_req <= w_sel;
            r_id  <= w_gnt[1];
            if (w_hit) r_result <= w_hit_data;
         end
         if (w_done) r_result <= md_result_i;
      end
   end

   assign md_operator_o      = r_req.op;
   assign md_signed_mode_o   = r_req.signed_mode;
   assign md_op_a_o          = r_req.op_a;
   assign md_op_b_o          = r_req.op_b;
   assign md_equal_to_zero_o = (r_req.op_b == 32'h0);
   assign rsp_id_o           = r_id;
   assign rsp_result_o       = r_result;

endmodule
